// File: rtl/nn_pkg.sv
//------------------------------------------------------------------------------
// nn_pkg : shared Q-format types, FSM encoding and multiply helper for the
//          hidden and output neuron stages.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package nn_pkg;

  localparam int NN_W    = 20;
  localparam int NN_FRAC = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_OUT  = 2'd3
  } hl_state_t;

  typedef logic signed [NN_W-1:0] q_t;

  // Hidden activations as handed to the output neuron stage
  typedef struct packed {
    q_t n1_1;
    q_t n1_2;
  } hidden_t;

  function automatic q_t q_mul_f(input q_t a, input q_t b);
    logic signed [2*NN_W-1:0] full;
    full = a * b;
    return NN_W'(full >>> NN_FRAC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/q_mul.sv
//------------------------------------------------------------------------------
// q_mul : combinational signed Q-format multiply (full product, >>> FRAC,
//         truncate to W).
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module q_mul
  import nn_pkg::*;
#(
  parameter int W    = NN_W,
  parameter int FRAC = NN_FRAC
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_p
);

  logic signed [2*W-1:0] w_full;

  assign w_full = i_a * i_b;
  // Arithmetic shift keeps negative products floored, then wrap to W bits
  assign o_p    = W'(w_full >>> FRAC);

endmodule

`default_nettype wire

// File: rtl/hidden_layer_seq.sv
//------------------------------------------------------------------------------
// hidden_layer_seq : two-neuron ReLU hidden layer, four MACs sequenced
//                    through one shared q_mul; 5-cycle latency, valid/ready.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module hidden_layer_seq
  import nn_pkg::*;
#(
  parameter int W    = NN_W,
  parameter int FRAC = NN_FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] X1,
  input  logic signed [W-1:0] X2,
  input  logic signed [W-1:0] W11,
  input  logic signed [W-1:0] W21,
  input  logic signed [W-1:0] W12,
  input  logic signed [W-1:0] W22,
  input  logic signed [W-1:0] B1,
  input  logic signed [W-1:0] B2,
  output logic signed [W-1:0] N1_1,
  output logic signed [W-1:0] N1_2,
  output logic                out_valid,
  input  logic                out_ready
);

  hl_state_t           r_state;
  hl_state_t           w_state_nxt;
  logic [1:0]          r_idx;
  logic signed [W-1:0] r_x1, r_x2;
  logic signed [W-1:0] r_w11, r_w21, r_w12, r_w22;
  logic signed [W-1:0] r_acc1, r_acc2;
  logic signed [W-1:0] r_n1_1, r_n1_2;
  logic                r_out_valid;
  logic signed [W-1:0] w_mul_a, w_mul_b, w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_MAC;
      end
      ST_MAC:  if (r_idx == 2'd3) w_state_nxt = ST_ACT;
      ST_ACT:  w_state_nxt = ST_OUT;
      ST_OUT:  if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // idx0/1 feed neuron 1 (X1,X2), idx2/3 feed neuron 2
  always_comb begin
    w_mul_a = r_idx[0] ? r_x2 : r_x1;
    case (r_idx)
      2'd0:    w_mul_b = r_w11;
      2'd1:    w_mul_b = r_w21;
      2'd2:    w_mul_b = r_w12;
      default: w_mul_b = r_w22;
    endcase
  end

  q_mul #(.W(W), .FRAC(FRAC)) u_q_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= 2'd0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_w11       <= '0;
      r_w21       <= '0;
      r_w12       <= '0;
      r_w22       <= '0;
      r_acc1      <= '0;
      r_acc2      <= '0;
      r_n1_1      <= '0;
      r_n1_2      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_x1   <= X1;
          r_x2   <= X2;
          r_w11  <= W11;
          r_w21  <= W21;
          r_w12  <= W12;
          r_w22  <= W22;
          r_acc1 <= B1;
          r_acc2 <= B2;
          r_idx  <= 2'd0;
        end
        ST_MAC: begin
          if (!r_idx[1]) r_acc1 <= r_acc1 + w_prod;
          else           r_acc2 <= r_acc2 + w_prod;
          r_idx <= r_idx + 2'd1;
        end
        ST_ACT: begin
          r_n1_1      <= r_acc1[W-1] ? '0 : r_acc1;
          r_n1_2      <= r_acc2[W-1] ? '0 : r_acc2;
          r_out_valid <= 1'b1;
        end
        ST_OUT: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign N1_1      = r_n1_1;
  assign N1_2      = r_n1_2;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_hidden_layer_seq.sv
//------------------------------------------------------------------------------
// tb_hidden_layer_seq : scoreboard bench for hidden_layer_seq with directed,
//                       hand-computed vectors.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hidden_layer_seq;

  typedef logic signed [19:0] d_t;
  typedef struct {
    d_t n1;
    d_t n2;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, out_valid, out_ready;
  d_t   X1, X2, W11, W21, W12, W22, B1, B2, N1_1, N1_2;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hidden_layer_seq #(.W(20), .FRAC(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X1        (X1),
    .X2        (X2),
    .W11       (W11),
    .W21       (W21),
    .W12       (W12),
    .W22       (W22),
    .B1        (B1),
    .B2        (B2),
    .N1_1      (N1_1),
    .N1_2      (N1_2),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every new result is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got out_valid=1 N1_1=%0d N1_2=%0d, expected no result",
                 N1_1, N1_2);
      end else begin
        mon_e = sb.pop_front();
        check("N1_1", N1_1, mon_e.n1);
        check("N1_2", N1_2, mon_e.n2);
        check("latency", cyc - mon_e.cyc, 5);
      end
    end
    prev_ov = out_valid;
  end

  task automatic issue(input d_t x1, input d_t x2, input d_t w11, input d_t w21,
                       input d_t w12, input d_t w22, input d_t b1, input d_t b2,
                       input d_t e1, input d_t e2, input bit expect_out,
                       input bit scramble);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
      return;
    end
    X1 = x1; X2 = x2; W11 = w11; W21 = w21; W12 = w12; W22 = w22; B1 = b1; B2 = b2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (expect_out) begin
      e.n1  = e1;
      e.n2  = e2;
      e.cyc = cyc;
      sb.push_back(e);
    end
    if (scramble) begin
      for (int k = 0; k < 5; k++) begin
        X1  = d_t'($urandom); X2  = d_t'($urandom);
        W11 = d_t'($urandom); W21 = d_t'($urandom);
        W12 = d_t'($urandom); W22 = d_t'($urandom);
        B1  = d_t'($urandom); B2  = d_t'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    in_valid = 1'b0; out_ready = 1'b1;
    X1 = '0; X2 = '0; W11 = '0; W21 = '0; W12 = '0; W22 = '0; B1 = '0; B2 = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_N1_1", N1_1, 0);
    check("rst_N1_2", N1_2, 0);
    check("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Basic: 0.5*1.0 + 1.0*0.5 = 1.0; neuron 2 clamps -0.5 to 0
    issue(16384, 32768, 32768, 16384, -32768, 0, 0, 0, 32768, 0, 1, 0);
    drain();
    // Bias only
    issue(32768, 32768, 0, 0, 0, 0, -100, 100, 0, 100, 1, 0);
    drain();
    // Negative products floor: -1*1 >>> 15 = -1, -1*65536 >>> 15 = -2
    issue(-1, 0, 1, 0, 65536, 0, 10, 100, 9, 98, 1, 0);
    drain();
    // Wrap: each product truncates to -16, sum -32, ReLU -> 0
    issue(262143, 262143, 262143, 262143, 0, 0, 0, 5, 0, 5, 1, 0);
    drain();
    // Wrap: each product 1048572 truncates to -4, 100 - 8 = 92
    issue(262143, 262143, 131072, 131072, 0, 0, 100, 0, 92, 0, 1, 0);
    drain();

    // Backpressure
    out_ready = 1'b0;
    issue(-1, 0, 1, 0, 65536, 0, 10, 100, 9, 98, 1, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_out_valid_seen", seen, 1);
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_N1_1", N1_1, 9);
      check("bp_N1_2", N1_2, 98);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_consumed_out_valid", out_valid, 0);
    check("bp_consumed_in_ready", in_ready, 1);
    check("bp_hold_N1_1", N1_1, 9);
    check("bp_hold_N1_2", N1_2, 98);
    drain();

    // Operand stability: inputs scrambled every cycle after accept
    issue(16384, 32768, 32768, 16384, -32768, 0, 1000, 20000, 33768, 3616, 1, 1);
    drain();

    // Reset mid-MAC at idx2
    issue(16384, 32768, 32768, 16384, -32768, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_N1_1", N1_1, 0);
    check("midrst_N1_2", N1_2, 0);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    repeat (10) @(negedge clk);
    check("midrst_no_out", out_valid, 0);

    // Recovery after reset
    issue(32768, 32768, 0, 0, 0, 0, -100, 100, 0, 100, 1, 0);
    drain();
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hidden_layer_seq.md
HIDDEN_LAYER_SEQ -- requirements
Module: hidden_layer_seq

Interface
REQ-001 The block SHALL have parameter W, default 20, meaning the signed data width of all inputs, weights, biases and outputs.
REQ-002 The block SHALL have parameter FRAC, default 15, meaning the number of fractional bits (Q4.15).
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have input in_valid, 1 bit: X/W/B operands are valid.
REQ-006 The block SHALL have output in_ready, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have signed inputs X1, X2, W bits each: network inputs.
REQ-008 The block SHALL have signed inputs W11, W21, W12, W22, W bits each: weights, where Wij is input i to hidden neuron j.
REQ-009 The block SHALL have signed inputs B1, B2, W bits each: hidden neuron biases.
REQ-010 The block SHALL have signed outputs N1_1, N1_2, W bits each: registered hidden activations that feed the output neuron stage.
REQ-011 The block SHALL have output out_valid, 1 bit: N1_1/N1_2 are valid.
REQ-012 The block SHALL have input out_ready, 1 bit: the downstream stage consumes the result.

Function
REQ-013 The block SHALL use exactly one W x W signed multiplier, time-shared across the four products.
REQ-014 The FSM SHALL have states IDLE, MAC, ACT and OUT.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 On an accept edge (IDLE, in_valid=1), the block SHALL:
- register X1, X2 and the four weights;
- load acc1=B1 and acc2=B2;
- set idx=0 and go to MAC.
REQ-017 In MAC, each edge SHALL add one product and then increment idx:
- idx0: acc1 += X1*W11
- idx1: acc1 += X2*W21
- idx2: acc2 += X1*W12
- idx3: acc2 += X2*W22, then go to ACT.
REQ-018 Product arithmetic SHALL be as follows:
- full 2W-bit signed product;
- arithmetic shift right by FRAC;
- keep bits [W-1:0];
- accumulate in W bits with two's-complement wrap, with no saturation.
REQ-019 The ACT edge SHALL write N1_k = (acc_k < 0) ? 0 : acc_k (ReLU), set out_valid=1 and go to OUT.
REQ-020 Latency SHALL be 5 cycles: out_valid rises on the 5th rising edge after the accept edge.
REQ-021 In OUT, N1_1, N1_2 and out_valid SHALL hold stable until out_ready=1.
REQ-022 On an OUT edge with out_ready=1, the block SHALL clear out_valid and go to IDLE, leaving the N1 values unchanged.
REQ-023 There SHALL be no accept in OUT; after consumption, the next accept is possible at the earliest one cycle later, so peak throughput is one result per 7 cycles.
REQ-024 in_valid SHALL be ignored outside IDLE, and operand input changes after acceptance SHALL have no effect.
REQ-025 out_ready SHALL be ignored when out_valid=0.

Reset
REQ-026 On rst_n=0, the block SHALL immediately (asynchronously) set:
- state=IDLE, idx=0;
- acc1=acc2=0 and all operand registers to 0;
- N1_1=N1_2=0, out_valid=0.
REQ-027 Reset asserted mid-MAC or mid-OUT SHALL abandon the computation, producing no partial output after release.
REQ-028 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-029 W, FRAC, the FSM state encoding and a Q-format multiply function (product, >>>FRAC, truncate to W) SHALL live in the shared package nn_pkg, alongside the types used by the output neuron.
REQ-030 The single multiplier plus shift/truncate SHALL be one sub-module, q_mul (combinational, parameterised by W and FRAC), reusable by the output neuron.

Verification
REQ-031 Basic: X1=16384, X2=32768, W11=32768, W21=16384, B1=0, W12=-32768, W22=0, B2=0 -> out_valid 5 edges after accept, N1_1=32768, N1_2=0 (ReLU clamp of -16384).
REQ-032 Bias/negative: X1=X2=32768, all weights 0, B1=-100, B2=100 -> N1_1=0, N1_2=100.
REQ-033 Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready=0; then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 the next cycle.
REQ-034 Wrap: X1=X2=262143, W11=W21=262143, B1=0 -> N1_1 equals the 20-bit wrapped sum of the truncated products, with ReLU applied to the wrapped value.
REQ-035 Reset mid-MAC: assert rst_n=0 at idx2 -> all outputs 0 immediately; after release, in_ready=1 and no spurious out_valid.
REQ-036 Operand stability: change inputs every cycle after accept -> results match the operands captured at accept.
